// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction memory and loads the IF/ID register.
// Handles decode stalls, branch/jump redirects with flush, and misaligned-target exceptions.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_out,
    output logic [31:0] inst,
    output logic        valid_o,
    output logic        exc_misalign_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_reg;
    logic [31:0] pc_f_reg;
    logic        rsp_v_reg;
    logic [31:0] pc_out_reg;
    logic [31:0] inst_reg;
    logic        valid_reg;
    logic        exc_reg;
    logic        target_aligned;
    logic [31:0] pc_f_plus4;

    assign target_aligned = (redirect_pc_i[1:0] == 2'b00);
    assign pc_f_plus4     = pc_f_reg + 32'd4;

    assign pc_out         = pc_out_reg;
    assign inst           = inst_reg;
    assign valid_o        = valid_reg;
    assign exc_misalign_o = exc_reg;

    // Memory request is combinational so a redirect target is fetched in the same cycle.
    always_comb begin
        imem_en_o   = 1'b0;
        imem_addr_o = pc_f_reg;
        if (rst) begin
            imem_en_o = 1'b0;
        end else if (redirect_i) begin
            imem_en_o = target_aligned;
            if (target_aligned)
                imem_addr_o = redirect_pc_i;
        end else begin
            case (state_reg)
                BOOT: begin
                    imem_en_o   = 1'b1;
                    imem_addr_o = RESET_PC;
                end
                RUN: begin
                    imem_en_o   = 1'b1;
                    // While stalled, re-present the same read so its data is fresh on release.
                    imem_addr_o = stall_i ? pc_f_reg : pc_f_plus4;
                end
                default: begin
                    imem_en_o = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= BOOT;
            pc_f_reg   <= RESET_PC;
            rsp_v_reg  <= 1'b0;
            pc_out_reg <= 32'h0000_0000;
            inst_reg   <= NOP;
            valid_reg  <= 1'b0;
            exc_reg    <= 1'b0;
        end else if (redirect_i) begin
            pc_out_reg <= redirect_pc_i;
            inst_reg   <= NOP;
            if (target_aligned) begin
                valid_reg <= 1'b0;
                exc_reg   <= 1'b0;
                pc_f_reg  <= redirect_pc_i;
                rsp_v_reg <= 1'b1;
                state_reg <= RUN;
            end else begin
                // The exception rides down the pipe as a valid entry; fetch stops until redirected.
                valid_reg <= 1'b1;
                exc_reg   <= 1'b1;
                rsp_v_reg <= 1'b0;
                state_reg <= HALT;
            end
        end else begin
            case (state_reg)
                BOOT: begin
                    rsp_v_reg <= 1'b1;
                    state_reg <= RUN;
                end
                RUN: begin
                    if (!stall_i) begin
                        pc_out_reg <= pc_f_reg;
                        inst_reg   <= rsp_v_reg ? imem_rdata_i : NOP;
                        valid_reg  <= rsp_v_reg;
                        exc_reg    <= 1'b0;
                        pc_f_reg   <= pc_f_plus4;
                        rsp_v_reg  <= 1'b1;
                    end
                end
                default: begin
                    if (!stall_i) begin
                        inst_reg  <= NOP;
                        valid_reg <= 1'b0;
                        exc_reg   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (RESET_PC 0x100 and 0xFFFF_FFF8) share stimulus; a directed
// vector table covers the listed scenarios, then random stimulus is checked against a stream model.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MKEY = 32'hA5A5_0000;
    localparam int          NVEC = 27;
    localparam int          MB   = 0;
    localparam int          MR   = 1;
    localparam int          MH   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;

    logic        en     [2];
    logic [31:0] addr   [2];
    logic [31:0] rdata  [2];
    logic [31:0] pc_o   [2];
    logic [31:0] inst_o [2];
    logic        v_o    [2];
    logic        e_o    [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0100), .NOP(NOP)) u_dut0 (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(tgt),
        .imem_en_o(en[0]), .imem_addr_o(addr[0]), .imem_rdata_i(rdata[0]),
        .pc_out(pc_o[0]), .inst(inst_o[0]), .valid_o(v_o[0]), .exc_misalign_o(e_o[0])
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(NOP)) u_dut1 (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(tgt),
        .imem_en_o(en[1]), .imem_addr_o(addr[1]), .imem_rdata_i(rdata[1]),
        .pc_out(pc_o[1]), .inst(inst_o[1]), .valid_o(v_o[1]), .exc_misalign_o(e_o[1])
    );

    // Synchronous-read memory: word at addr = addr ^ 0xA5A5_0000.
    always_ff @(posedge clk) begin
        if (en[0]) rdata[0] <= addr[0] ^ MKEY;
        if (en[1]) rdata[1] <= addr[1] ^ MKEY;
    end

    // Reference model: mode plus the program address of the next instruction due in IF/ID.
    logic [31:0] rpc   [2];
    int          mmode [2];
    logic [31:0] mexp  [2];
    logic [31:0] mpc   [2];
    logic [31:0] minst [2];
    logic        mv    [2];
    logic        me    [2];
    logic        mok = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic model_update(input logic r, input logic s, input logic d, input logic [31:0] t);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                mpc[i] = 32'h0; minst[i] = NOP; mv[i] = 1'b0; me[i] = 1'b0;
                mmode[i] = MB; mexp[i] = rpc[i];
            end else if (mok) begin
                if (d) begin
                    mpc[i] = t; minst[i] = NOP;
                    if (t[1:0] == 2'b00) begin
                        mv[i] = 1'b0; me[i] = 1'b0; mmode[i] = MR; mexp[i] = t;
                    end else begin
                        mv[i] = 1'b1; me[i] = 1'b1; mmode[i] = MH;
                    end
                end else if (mmode[i] == MB) begin
                    mmode[i] = MR;
                end else if (mmode[i] == MR) begin
                    if (!s) begin
                        mpc[i] = mexp[i]; minst[i] = mexp[i] ^ MKEY; mv[i] = 1'b1; me[i] = 1'b0;
                        mexp[i] = mexp[i] + 32'd4;
                    end
                end else if (!s) begin
                    minst[i] = NOP; mv[i] = 1'b0; me[i] = 1'b0;
                end
            end
        end
        if (r) mok = 1'b1;
    endtask

    // One clock: drive inputs, check the memory request mid-cycle, step model, check IF/ID.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] t,
                         input logic use_tbl, input logic tbl_en);
        logic        xen;
        logic [31:0] xaddr;
        rst = r; stall = s; redir = d; tgt = t;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r || mok) begin
                xaddr = mexp[i];
                if (r)               xen = 1'b0;
                else if (d)          xen = (t[1:0] == 2'b00);
                else                 xen = (mmode[i] != MH);
                if (!r && d)                 xaddr = t;
                else if (mmode[i] == MB)     xaddr = rpc[i];
                else if (!s)                 xaddr = mexp[i] + 32'd4;
                chk($sformatf("imem_en[%0d]", i), {31'd0, en[i]}, {31'd0, xen});
                if (xen) chk($sformatf("imem_addr[%0d]", i), addr[i], xaddr);
                if (en[i]) chk($sformatf("addr_align[%0d]", i), {30'd0, addr[i][1:0]}, 32'd0);
            end
            if (use_tbl) chk($sformatf("tbl_en[%0d]", i), {31'd0, en[i]}, {31'd0, tbl_en});
        end
        @(posedge clk);
        model_update(r, s, d, t);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pc_out[%0d]", i), pc_o[i], mpc[i]);
            chk($sformatf("inst[%0d]", i), inst_o[i], minst[i]);
            chk($sformatf("valid[%0d]", i), {31'd0, v_o[i]}, {31'd0, mv[i]});
            chk($sformatf("exc[%0d]", i), {31'd0, e_o[i]}, {31'd0, me[i]});
        end
    endtask

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] tgt;
        logic        en, v, e;
        logic [31:0] pc0, pc1;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] t,
                                logic xen, logic xv, logic xe, logic [31:0] p0, logic [31:0] p1);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = d; x.tgt = t;
        x.en = xen; x.v = xv; x.e = xe; x.pc0 = p0; x.pc1 = p1;
        return x;
    endfunction

    initial begin
        logic [31:0] xi;
        logic        r, s, d;
        logic [31:0] t;
        rpc[0] = 32'h0000_0100;
        rpc[1] = 32'hFFFF_FFF8;
        rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'h0;

        //             rst   stall redir tgt            en    v     e     pc0            pc1
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h100,      32'hFFFF_FFF8);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h104,      32'hFFFF_FFFC);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h108,      32'h0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h108,      32'h0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h108,      32'h0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h108,      32'h0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10C,      32'h4);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 1'b0, 32'h200,      32'h200);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h200,      32'h200);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h204,      32'h204);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 32'h300,      1'b1, 1'b0, 1'b0, 32'h300,      32'h300);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h300,      32'h300);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h300,      32'h300);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h304,      32'h304);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 32'h402,      1'b0, 1'b1, 1'b1, 32'h402,      32'h402);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h402,      32'h402);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h402,      32'h402);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h402,      32'h402);
        tbl[21] = mk(1'b0, 1'b0, 1'b1, 32'h400,      1'b1, 1'b0, 1'b0, 32'h400,      32'h400);
        tbl[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h400,      32'h400);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h404,      32'h404);
        tbl[24] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[26] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h100,      32'hFFFF_FFF8);

        for (int k = 0; k < NVEC; k++) begin
            cycle(tbl[k].rst, tbl[k].stall, tbl[k].redir, tbl[k].tgt, 1'b1, tbl[k].en);
            xi = (tbl[k].v && !tbl[k].e) ? (tbl[k].pc0 ^ MKEY) : NOP;
            chk("tbl_pc0", pc_o[0], tbl[k].pc0);
            chk("tbl_pc1", pc_o[1], tbl[k].pc1);
            chk("tbl_inst0", inst_o[0], xi);
            chk("tbl_valid0", {31'd0, v_o[0]}, {31'd0, tbl[k].v});
            chk("tbl_valid1", {31'd0, v_o[1]}, {31'd0, tbl[k].v});
            chk("tbl_exc0", {31'd0, e_o[0]}, {31'd0, tbl[k].e});
            $display("vec %0d rst=%0b stall=%0b redir=%0b tgt=%h -> pc0=%h pc1=%h v=%0b e=%0b",
                     k, tbl[k].rst, tbl[k].stall, tbl[k].redir, tbl[k].tgt,
                     pc_o[0], pc_o[1], v_o[0], e_o[0]);
        end

        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 9) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t[31:8] = 24'hFFFFFF;
            cycle(r, s, d, t, 1'b0, 1'b0);
            $display("rnd %0d rst=%0b stall=%0b redir=%0b tgt=%h -> pc0=%h v0=%0b pc1=%h v1=%0b",
                     n, r, s, d, t, pc_o[0], v_o[0], pc_o[1], v_o[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
